// File: rtl/out_ram_streamer_if.sv
// Byte-stream handshake between the output-RAM streamer and its consumer.
// The master drives valid/data/last; the slave returns ready.
interface out_ram_streamer_if;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/out_ram_streamer.sv
// Reads the packed output RAM word by word and streams each word as two bytes,
// low byte first, with last-byte flag, running mod-256 checksum and a done pulse.
module out_ram_streamer #(
  parameter int WORDS  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_in,
  input  logic                      flush_in,
  output logic [ADDR_W-1:0]         ram_rd_addr,
  input  logic [DATA_W-1:0]         ram_rd_data,
  out_ram_streamer_if.master        m_if,
  output logic                      busy,
  output logic                      done_pulse,
  output logic [7:0]                checksum
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND_LO, SEND_HI, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(WORDS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   word_cnt;
  logic [DATA_W-1:0]   word_reg;
  logic                start_q;
  logic                start_edge;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign start_edge = start_in & ~start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      word_cnt      <= '0;
      word_reg      <= '0;
      start_q       <= 1'b0;
      ram_rd_addr   <= '0;
      m_if.m_valid  <= 1'b0;
      m_if.m_data   <= 8'h00;
      m_if.m_last   <= 1'b0;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      checksum      <= 8'h00;
    end else begin
      start_q    <= start_in;
      done_pulse <= 1'b0;
      if (flush_in) begin
        // Abort keeps the partial checksum so the consumer can inspect it.
        state        <= IDLE;
        word_cnt     <= '0;
        ram_rd_addr  <= '0;
        m_if.m_valid <= 1'b0;
        m_if.m_last  <= 1'b0;
        busy         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_edge) begin
              word_cnt    <= '0;
              ram_rd_addr <= '0;
              checksum    <= 8'h00;
              busy        <= 1'b1;
              state       <= LOAD;
            end
          end
          LOAD: begin
            // Address was registered last cycle, so the async read is settled here.
            word_reg     <= ram_rd_data;
            m_if.m_data  <= ram_rd_data[7:0];
            m_if.m_valid <= 1'b1;
            m_if.m_last  <= 1'b0;
            state        <= SEND_LO;
          end
          SEND_LO: begin
            if (m_if.m_ready) begin
              checksum    <= csum_add(checksum, m_if.m_data);
              m_if.m_data <= word_reg[DATA_W-1:8];
              m_if.m_last <= (word_cnt == LAST_IDX);
              state       <= SEND_HI;
            end
          end
          SEND_HI: begin
            if (m_if.m_ready) begin
              checksum     <= csum_add(checksum, m_if.m_data);
              m_if.m_valid <= 1'b0;
              m_if.m_last  <= 1'b0;
              if (word_cnt == LAST_IDX) begin
                done_pulse <= 1'b1;
                state      <= DONE;
              end else begin
                word_cnt    <= word_cnt + 1'b1;
                ram_rd_addr <= word_cnt + 1'b1;
                state       <= LOAD;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_out_ram_streamer.sv
// Bench for out_ram_streamer: table of runs against a queue-based model,
// plus hand-written reset, flush and start-edge sequences.
module tb_out_ram_streamer;
  localparam int WORDS  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_in;
  logic              flush_in;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_rd_data;
  logic              busy;
  logic              done_pulse;
  logic [7:0]        checksum;
  logic [15:0]       ram [WORDS];

  out_ram_streamer_if bus ();

  out_ram_streamer #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_in    (start_in),
    .flush_in    (flush_in),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .m_if        (bus),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .checksum    (checksum)
  );

  assign ram_rd_data = ram[ram_rd_addr];

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int exp_csum;
  int n_done, done_cyc, n_last, last_idx;
  bit stable_ok;

  typedef struct {
    int pat;       // 0: incrementing bytes, 1: all 0xFF, 2: random
    int rdy_pct;
    int exp_n;
    int exp_cs;    // -1: take from model
    int exp_done;  // -1: latency not checked
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fill(input int pat);
    for (int i = 0; i < WORDS; i++) begin
      case (pat)
        0:       ram[i] = {8'(2*i+1), 8'(2*i)};
        1:       ram[i] = 16'hFFFF;
        default: ram[i] = 16'($urandom);
      endcase
    end
  endtask

  // Expected stream: every word low byte then high byte; checksum is the byte sum mod 256.
  task automatic build_model();
    int s;
    exp_q.delete();
    s = 0;
    for (int i = 0; i < WORDS; i++) begin
      exp_q.push_back(ram[i][7:0]);
      exp_q.push_back(ram[i][15:8]);
      s = s + ram[i][7:0] + ram[i][15:8];
    end
    exp_csum = s % 256;
  endtask

  task automatic begin_run();
    start_in = 1'b0;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    start_in = 1'b1;
  endtask

  task automatic run(input int rdy_pct, input int budget, input int stop_n, input bit toggle);
    logic pv, pr, pl;
    logic [7:0] pd;
    got.delete();
    n_done = 0; done_cyc = -1; n_last = 0; last_idx = -1; stable_ok = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      bus.m_ready = ($urandom_range(99) < rdy_pct);
      pv = bus.m_valid; pd = bus.m_data; pl = bus.m_last; pr = bus.m_ready;
      @(posedge clk); #1;
      if (pv && pr) begin
        if (pl) begin n_last++; last_idx = got.size(); end
        got.push_back(pd);
      end else if (pv && (bus.m_valid !== 1'b1 || bus.m_data !== pd || bus.m_last !== pl)) begin
        stable_ok = 1'b0;
      end
      if (done_pulse) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (toggle && c >= 10 && c <= 40 && (c % 3) == 0) start_in = ~start_in;
      if (stop_n > 0 && got.size() == stop_n) return;
    end
  endtask

  task automatic cmp_seq(input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) nbad++;
    chk({name, "_len"}, got.size(), exp_q.size());
    chk({name, "_bad_bytes"}, nbad, 0);
  endtask

  task automatic full_checks(input string name, input int exp_cs, input int exp_done);
    cmp_seq(name);
    chk({name, "_checksum"}, int'(checksum), exp_cs);
    chk({name, "_done_pulses"}, n_done, 1);
    chk({name, "_last_count"}, n_last, 1);
    chk({name, "_last_index"}, last_idx, 2*WORDS-1);
    chk({name, "_hold_stable"}, int'(stable_ok), 1);
    chk({name, "_busy_after"}, int'(busy), 0);
    if (exp_done > 0) chk({name, "_done_cycle"}, done_cyc + 1, exp_done);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_m_valid"}, int'(bus.m_valid), 0);
    chk({name, "_m_data"}, int'(bus.m_data), 0);
    chk({name, "_m_last"}, int'(bus.m_last), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done_pulse), 0);
    chk({name, "_checksum"}, int'(checksum), 0);
    chk({name, "_addr"}, int'(ram_rd_addr), 0);
  endtask

  initial begin
    int cnt_v, cnt_d;
    vecs[0] = '{pat: 0, rdy_pct: 100, exp_n: 32, exp_cs: 'hF0, exp_done: 50};
    vecs[1] = '{pat: 0, rdy_pct: 50,  exp_n: 32, exp_cs: 'hF0, exp_done: -1};
    vecs[2] = '{pat: 1, rdy_pct: 100, exp_n: 32, exp_cs: 'hE0, exp_done: 50};
    vecs[3] = '{pat: 2, rdy_pct: 60,  exp_n: 32, exp_cs: -1,   exp_done: -1};
    vecs[4] = '{pat: 2, rdy_pct: 100, exp_n: 32, exp_cs: -1,   exp_done: 50};

    rst = 1'b1; start_in = 1'b0; flush_in = 1'b0; bus.m_ready = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      fill(vecs[v].pat);
      build_model();
      begin_run();
      run(vecs[v].rdy_pct, 400, 0, 1'b0);
      chk($sformatf("vec%0d_nbytes", v), got.size(), vecs[v].exp_n);
      full_checks($sformatf("vec%0d", v),
                  (vecs[v].exp_cs < 0) ? exp_csum : vecs[v].exp_cs, vecs[v].exp_done);
    end

    // Held start produces one run only; toggling during a run adds nothing.
    fill(0);
    build_model();
    begin_run();
    run(100, 200, 0, 1'b0);
    chk("held_nbytes", got.size(), 32);
    chk("held_done_pulses", n_done, 1);
    begin_run();
    run(100, 120, 0, 1'b1);
    chk("toggle_nbytes", got.size(), 32);
    chk("toggle_done_pulses", n_done, 1);
    chk("toggle_checksum", int'(checksum), 'hF0);

    // Asynchronous reset right after byte 0x09.
    begin_run();
    run(100, 100, 10, 1'b0);
    chk("rst_pre_nbytes", got.size(), 10);
    if (got.size() == 10) chk("rst_pre_lastbyte", int'(got[9]), 'h09);
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    start_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_idle_busy", int'(busy), 0);
    chk("rst_idle_valid", int'(bus.m_valid), 0);
    begin_run();
    run(100, 200, 0, 1'b0);
    full_checks("after_rst", 'hF0, 50);

    // Flush after byte 0x04 is accepted.
    begin_run();
    run(100, 100, 5, 1'b0);
    chk("flush_pre_nbytes", got.size(), 5);
    flush_in = 1'b1;
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    flush_in = 1'b0;
    chk("flush_valid", int'(bus.m_valid), 0);
    chk("flush_busy", int'(busy), 0);
    chk("flush_checksum", int'(checksum), 'h0A);
    cnt_v = 0; cnt_d = 0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (bus.m_valid) cnt_v++;
      if (done_pulse) cnt_d++;
    end
    chk("flush_no_valid", cnt_v, 0);
    chk("flush_no_done", cnt_d, 0);
    begin_run();
    run(100, 200, 0, 1'b0);
    full_checks("after_flush", 'hF0, 50);

    // Edge coinciding with flush is dropped.
    start_in = 1'b0;
    @(posedge clk); #1;
    start_in = 1'b1;
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_edge_dropped_busy", int'(busy), 0);
    chk("flush_edge_dropped_valid", int'(bus.m_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
